// File: rtl/io_pkg.sv
// Shared constants, FSM state encoding and sizing helper for the decimal print port.
package io_pkg;

    localparam logic [7:0] ASCII_ZERO = 8'h30;
    localparam logic [7:0] ASCII_NL   = 8'h0A;

    typedef enum logic [2:0] {
        IDLE,
        CONV,
        SKIP,
        EMIT,
        NL
    } state_t;

    // ceil(width * log10(2)), log10(2) approximated as 0.30103
    function automatic int unsigned min_digits(input int unsigned width);
        return (width * 30103 + 99999) / 100000;
    endfunction

endpackage

// File: rtl/io_sync_fifo.sv
// Synchronous word FIFO with first-word fall-through head and registered occupancy.
module io_sync_fifo #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [DATA_W-1:0]        wdata,
    input  logic                     pop,
    output logic [DATA_W-1:0]        head_c,
    output logic                     full_c,
    output logic                     empty_c,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W:0]    wr_ptr;
    logic [PTR_W:0]    rd_ptr;
    logic              do_push;
    logic              do_pop;

    // Extra pointer MSB distinguishes full from empty when the indices match
    assign full_c  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) && (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign empty_c = (wr_ptr == rd_ptr);
    assign head_c  = mem[rd_ptr[PTR_W-1:0]];
    assign do_push = push && !full_c;
    assign do_pop  = pop && !empty_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (PTR_W+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (PTR_W+1)'(1);
            level <= level + LVL_W'(do_push) - LVL_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[PTR_W-1:0]] <= wdata;
    end

endmodule

// File: rtl/io_dec_printer.sv
// Turns each io_write rising edge into an unsigned decimal ASCII line on a valid/ready byte stream.
module io_dec_printer
    import io_pkg::*;
#(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned DIGITS  = min_digits(DATA_W),
    parameter int unsigned DEPTH   = 4,
    parameter logic [7:0]  NL_CHAR = ASCII_NL
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     io_write,
    input  logic [DATA_W-1:0]        io_data,
    output logic [7:0]               tx_data,
    output logic                     tx_valid,
    input  logic                     tx_ready,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     overflow
);

    localparam int unsigned LVL_W = $clog2(DEPTH) + 1;
    localparam int unsigned BCD_W = DIGITS * 4;
    localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned CNT_W = $clog2(DATA_W);

    state_t            state, state_nxt;
    logic              prev;
    logic [DATA_W-1:0] shift, shift_nxt;
    logic [BCD_W-1:0]  bcd, bcd_nxt, bcd_adj;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [IDX_W-1:0]  idx, idx_nxt, msd;
    logic [3:0]        dig_cur, dig_next;
    logic [7:0]        tx_data_nxt;
    logic              tx_valid_nxt;
    logic              busy_nxt;
    logic [LVL_W-1:0]  lvl_nxt;
    logic              accept_c, push_ok_c, pop_c;
    logic [DATA_W-1:0] head_c;
    logic              full_c, empty_c;

    assign accept_c  = io_write && !prev;
    assign push_ok_c = accept_c && !full_c;

    io_sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (accept_c),
        .wdata   (io_data),
        .pop     (pop_c),
        .head_c  (head_c),
        .full_c  (full_c),
        .empty_c (empty_c),
        .level   (fifo_level)
    );

    // Edge detector and sticky drop flag; a full FIFO drops even if a pop happens this cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            prev     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            prev <= io_write;
            if (accept_c && full_c) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            shift    <= '0;
            bcd      <= '0;
            cnt      <= '0;
            idx      <= '0;
            tx_data  <= '0;
            tx_valid <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_nxt;
            shift    <= shift_nxt;
            bcd      <= bcd_nxt;
            cnt      <= cnt_nxt;
            idx      <= idx_nxt;
            tx_data  <= tx_data_nxt;
            tx_valid <= tx_valid_nxt;
            busy     <= busy_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        shift_nxt    = shift;
        bcd_nxt      = bcd;
        cnt_nxt      = cnt;
        idx_nxt      = idx;
        tx_data_nxt  = tx_data;
        tx_valid_nxt = tx_valid;
        pop_c        = 1'b0;
        bcd_adj      = bcd;
        msd          = '0;
        dig_cur      = '0;
        dig_next     = '0;

        // Digit taps: add-3 correction, top nonzero digit, current and next digit to print
        for (int unsigned d = 0; d < DIGITS; d++) begin
            if (bcd[d*4 +: 4] >= 4'd5) bcd_adj[d*4 +: 4] = bcd[d*4 +: 4] + 4'd3;
            if (bcd[d*4 +: 4] != 4'd0) msd = IDX_W'(d);
            if (IDX_W'(d) == idx)      dig_cur = bcd[d*4 +: 4];
            if (IDX_W'(d + 1) == idx)  dig_next = bcd[d*4 +: 4];
        end

        case (state)
            IDLE: begin
                if (!empty_c) begin
                    pop_c     = 1'b1;
                    shift_nxt = head_c;
                    bcd_nxt   = '0;
                    cnt_nxt   = '0;
                    state_nxt = CONV;
                end
            end
            CONV: begin
                bcd_nxt   = {bcd_adj[BCD_W-2:0], shift[DATA_W-1]};
                shift_nxt = {shift[DATA_W-2:0], 1'b0};
                cnt_nxt   = cnt + CNT_W'(1);
                if (cnt == CNT_W'(DATA_W - 1)) state_nxt = SKIP;
            end
            SKIP: begin
                idx_nxt   = msd;
                state_nxt = EMIT;
            end
            EMIT: begin
                if (!tx_valid) begin
                    tx_valid_nxt = 1'b1;
                    tx_data_nxt  = ASCII_ZERO + {4'h0, dig_cur};
                end else if (tx_ready) begin
                    if (idx == '0) begin
                        tx_data_nxt = NL_CHAR;
                        state_nxt   = NL;
                    end else begin
                        idx_nxt     = idx - IDX_W'(1);
                        tx_data_nxt = ASCII_ZERO + {4'h0, dig_next};
                    end
                end
            end
            NL: begin
                if (tx_ready) begin
                    tx_valid_nxt = 1'b0;
                    state_nxt    = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase

        lvl_nxt  = fifo_level + LVL_W'(push_ok_c) - LVL_W'(pop_c);
        busy_nxt = (state_nxt != IDLE) || (lvl_nxt != '0);
    end

endmodule
